// File: rtl/ibex_l2_rf_ctrl_if.sv
// Request/response channel between a requester and the L2 register-file
// front-end. The requester drives the request side and consumes responses.
interface ibex_l2_rf_ctrl_if #(
  parameter int DataWidth = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [4:0]           req_addr;
  logic [DataWidth-1:0] req_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );
endinterface

// File: rtl/ibex_l2_rf_ctrl.sv
// Front-end for the L2 register file: single reads/writes over a valid/ready
// channel plus DUMP (stream regs 1..NumRegs-1) and CLEAR (zero regs
// 1..NumRegs-1). The file has one addr/wdata/we port and a 1-cycle read
// latency; only one operation is in flight at a time.
module ibex_l2_rf_ctrl #(
  parameter int DataWidth = 32,
  parameter int NumRegs   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_l2_rf_ctrl_if.slave     bus,
  input  logic                 dump_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic [4:0]           rf_addr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  input  logic [DataWidth-1:0] rf_rdata_i
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRsp    = 2'd2,
    StClear  = 2'd3
  } state_e;

  // Index of the highest implemented register; terminates DUMP and CLEAR.
  localparam logic [4:0] LastIdx = 5'(NumRegs - 1);

  state_e               state_q, state_d;
  logic                 dump_mode_q, dump_mode_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [4:0]           addr_q, addr_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;

  // Register 0 is hardwired to zero and indices at or above NumRegs do not
  // exist: writes there are dropped and reads return zero.
  function automatic logic mapped(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < 6'(NumRegs));
  endfunction

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      dump_mode_q <= 1'b0;
      cnt_q       <= 5'd1;
      addr_q      <= 5'd0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dump_mode_q <= dump_mode_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // Next-state logic and register-file port drive.
  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    dump_mode_d   = dump_mode_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_last_d    = rsp_last_q;
    bus.req_ready = 1'b0;
    rf_addr_o     = addr_q;
    rf_wdata_o    = '0;
    rf_we_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Bulk commands win over a pending request; the request is held off.
        bus.req_ready = !clear_i && !dump_i;
        if (clear_i) begin
          cnt_d   = 5'd1;
          state_d = StClear;
        end else if (dump_i) begin
          dump_mode_d = 1'b1;
          cnt_d       = 5'd1;
          addr_d      = 5'd1;
          rf_addr_o   = 5'd1;
          state_d     = StRdWait;
        end else if (bus.req_valid) begin
          rf_addr_o = bus.req_addr;
          if (bus.req_we) begin
            // Writes complete in the accept cycle and produce no response.
            if (mapped(bus.req_addr)) begin
              rf_we_o    = 1'b1;
              rf_wdata_o = bus.req_wdata;
            end
          end else begin
            addr_d      = bus.req_addr;
            dump_mode_d = 1'b0;
            state_d     = StRdWait;
          end
        end
      end

      StRdWait: begin
        // Read data for the address presented last cycle arrives now.
        rsp_data_d = mapped(addr_q) ? rf_rdata_i : '0;
        rsp_last_d = !dump_mode_q || (cnt_q == LastIdx);
        state_d    = StRsp;
      end

      StRsp: begin
        if (bus.rsp_ready) begin
          if (dump_mode_q && !rsp_last_q) begin
            // Present the next address in the handshake cycle so its data is
            // ready in the following RD_WAIT cycle.
            cnt_d     = cnt_q + 5'd1;
            addr_d    = addr_q + 5'd1;
            rf_addr_o = addr_q + 5'd1;
            state_d   = StRdWait;
          end else begin
            dump_mode_d = 1'b0;
            cnt_d       = 5'd1;
            state_d     = StIdle;
          end
        end
      end

      StClear: begin
        rf_addr_o = cnt_q;
        rf_we_o   = 1'b1;
        if (cnt_q == LastIdx) begin
          cnt_d   = 5'd1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Response channel and status are straight from registered state.
  assign bus.rsp_valid = (state_q == StRsp);
  assign bus.rsp_rdata = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_ibex_l2_rf_ctrl.sv
// Directed bench for ibex_l2_rf_ctrl with a behavioural 1-cycle-latency
// register file attached to the rf_* port.
module tb_ibex_l2_rf_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        dump;
  logic        clear;
  logic        busy;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int we_cycles = 0;

  logic [31:0] rf_mem [32];

  ibex_l2_rf_ctrl_if #(.DataWidth(32)) bus ();

  ibex_l2_rf_ctrl #(.DataWidth(32), .NumRegs(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .dump_i     (dump),
    .clear_i    (clear),
    .busy_o     (busy),
    .rf_addr_o  (rf_addr),
    .rf_wdata_o (rf_wdata),
    .rf_we_o    (rf_we),
    .rf_rdata_i (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file: data for addr appears one cycle later.
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_addr];
  end

  // Count cycles with the write strobe high, sampled mid-cycle.
  always @(negedge clk) begin
    if (rf_we === 1'b1) we_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single write; starts and ends 1 time unit after a rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic exp_we);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    check("wr_ready", 32'(bus.req_ready), 1);
    check("wr_we",    32'(rf_we), 32'(exp_we));
    check("wr_addr",  32'(rf_addr), 32'(a));
    check("wr_wdata", rf_wdata, exp_we ? d : 32'h0);
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  // Single read, holding rsp_ready low for 'hold' cycles once the response shows.
  task automatic do_read(input logic [4:0] a, input logic [31:0] exp_d, input int hold);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    #1;
    check("rd_ready", 32'(bus.req_ready), 1);
    check("rd_addr",  32'(rf_addr), 32'(a));
    check("rd_we",    32'(rf_we), 0);
    tick();
    bus.req_valid = 1'b0;
    check("rd_busy",       32'(busy), 1);
    check("rd_early_valid", 32'(bus.rsp_valid), 0);
    tick();
    check("rd_valid", 32'(bus.rsp_valid), 1);
    check("rd_rdata", bus.rsp_rdata, exp_d);
    check("rd_last",  32'(bus.rsp_last), 1);
    for (int i = 0; i < hold; i++) begin
      // A competing request while busy must be ignored.
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'd1;
      #1;
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_rdata", bus.rsp_rdata, exp_d);
      check("hold_ready", 32'(bus.req_ready), 0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rd_idle_busy",  32'(busy), 0);
    check("rd_idle_valid", 32'(bus.rsp_valid), 0);
    check("rd_idle_ready", 32'(bus.req_ready), 1);
  endtask

  // DUMP; consumes 'stop_after' responses. zeros: expect 0, else 0x100+r.
  task automatic run_dump(input bit zeros, input bit rand_ready, input int stop_after);
    int idx;
    int budget;
    dump = 1'b1;
    #1;
    check("dump_req_ready", 32'(bus.req_ready), 0);
    check("dump_first_addr", 32'(rf_addr), 1);
    tick();
    dump = 1'b0;
    idx = 1;
    budget = 0;
    while (idx <= stop_after && budget < 2000) begin
      bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("dump_rdata", bus.rsp_rdata, zeros ? 32'h0 : 32'h100 + 32'(idx));
        check("dump_last",  32'(bus.rsp_last), (idx == 31) ? 1 : 0);
        idx++;
      end
      tick();
      budget++;
    end
    bus.rsp_ready = 1'b0;
    check("dump_count", 32'(idx), 32'(stop_after + 1));
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst_ni        = 1'b0;
    dump          = 1'b0;
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_busy",   32'(busy), 0);
    check("rst_ready",  32'(bus.req_ready), 1);
    check("rst_valid",  32'(bus.rsp_valid), 0);
    check("rst_rdata",  bus.rsp_rdata, 0);
    check("rst_last",   32'(bus.rsp_last), 0);
    check("rst_we",     32'(rf_we), 0);
    check("rst_addr",   32'(rf_addr), 0);
    check("rst_wdata",  rf_wdata, 0);
    rst_ni = 1'b1;
    tick();

    // 1: write/read addr 5, write strobe exactly one cycle
    w0 = we_cycles;
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    check("t1_we_cycles", 32'(we_cycles - w0), 1);
    do_read(5'd5, 32'hDEADBEEF, 0);
    check("t1_we_cycles_after_read", 32'(we_cycles - w0), 1);

    // 2: addr 0 write is swallowed, read returns 0
    w0 = we_cycles;
    do_write(5'd0, 32'h00001234, 1'b0);
    do_read(5'd0, 32'h0, 0);
    check("t2_we_cycles", 32'(we_cycles - w0), 0);

    // 3: held response on addr 7
    do_write(5'd7, 32'h07070707, 1'b1);
    do_read(5'd7, 32'h07070707, 5);

    // 4: fill r = 0x100+r, dump with random backpressure
    for (int r = 1; r < 32; r++) do_write(5'(r), 32'h100 + 32'(r), 1'b1);
    w0 = we_cycles;
    run_dump(1'b0, 1'b1, 31);
    check("t4_idle", 32'(busy), 0);
    check("t4_no_writes", 32'(we_cycles - w0), 0);

    // 5: clear beats a simultaneous write request
    clear         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd3;
    bus.req_wdata = 32'hAAAA5555;
    #1;
    check("t5_req_ready", 32'(bus.req_ready), 0);
    check("t5_we_start",  32'(rf_we), 0);
    tick();
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    for (int i = 1; i < 32; i++) begin
      #1;
      check("t5_clr_we",    32'(rf_we), 1);
      check("t5_clr_addr",  32'(rf_addr), 32'(i));
      check("t5_clr_wdata", rf_wdata, 0);
      tick();
    end
    check("t5_idle",    32'(busy), 0);
    check("t5_we_done", 32'(rf_we), 0);
    run_dump(1'b1, 1'b0, 31);

    // 6: reset during DUMP while reading reg 10
    for (int r = 1; r < 32; r++) do_write(5'(r), 32'h100 + 32'(r), 1'b1);
    run_dump(1'b0, 1'b0, 9);
    check("t6_busy_before", 32'(busy), 1);
    check("t6_addr_before", 32'(rf_addr), 10);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_valid", 32'(bus.rsp_valid), 0);
    check("t6_rst_ready", 32'(bus.req_ready), 1);
    check("t6_rst_addr",  32'(rf_addr), 0);
    check("t6_rst_rdata", bus.rsp_rdata, 0);
    check("t6_rst_last",  32'(bus.rsp_last), 0);
    check("t6_rst_we",    32'(rf_we), 0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_quiet_valid", 32'(bus.rsp_valid), 0);
      check("t6_quiet_busy",  32'(busy), 0);
    end
    do_write(5'd9, 32'h00000099, 1'b1);
    do_read(5'd9, 32'h00000099, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
